// File: rtl/iob_ibus_dbus_merge_pkg.sv
// Shared widths, field offsets and master ids for the ibus/dbus merge.
// Requests are {avalid,addr,wdata,wstrb}; responses are {rdata,rvalid,ready}.
package iob_ibus_dbus_merge_pkg;

    localparam logic ID_IBUS = 1'b0;
    localparam logic ID_DBUS = 1'b1;

    localparam int WSTRB_OFF  = 32'sd0;
    localparam int READY_OFF  = 32'sd0;
    localparam int RVALID_OFF = 32'sd1;
    localparam int RDATA_OFF  = 32'sd2;

    function automatic int wstrb_w(input int data_w);
        return data_w / 32'sd8;
    endfunction

    function automatic int req_w(input int addr_w, input int data_w);
        return 32'sd1 + addr_w + data_w + wstrb_w(data_w);
    endfunction

    function automatic int resp_w(input int data_w);
        return data_w + 32'sd2;
    endfunction

    function automatic int wdata_off(input int data_w);
        return wstrb_w(data_w);
    endfunction

    function automatic int address_off(input int data_w);
        return wstrb_w(data_w) + data_w;
    endfunction

    function automatic int avalid_off(input int addr_w, input int data_w);
        return req_w(addr_w, data_w) - 32'sd1;
    endfunction

endpackage

// File: rtl/iob_ibus_dbus_merge_id_fifo.sv
// Small synchronous FIFO of 1-bit master ids, one entry per outstanding read.
module iob_id_fifo
    import iob_ibus_dbus_merge_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             cke,
    input  logic             rst,
    input  logic             push,
    input  logic             din,
    input  logic             pop,
    output logic             dout,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic             mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
    endfunction

    // Qualified push/pop: never overflow or underflow even if the caller misbehaves.
    always_comb begin
        do_pop_s  = pop & ~empty;
        do_push_s = push & (~full | do_pop_s);
    end

    // Id storage; contents are meaningless while the matching slot is empty.
    always_ff @(posedge clk) begin
        if (cke && do_push_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy state.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else if (cke) begin
            if (do_push_s) wr_ptr_r <= ptr_inc(wr_ptr_r);
            if (do_pop_s)  rd_ptr_r <= ptr_inc(rd_ptr_r);
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = (count_r == CNT_W'(DEPTH));
    assign empty = (count_r == {CNT_W{1'b0}});
    assign count = count_r;

endmodule

// File: rtl/iob_ibus_dbus_merge.sv
// Merges instruction and data IOb masters onto one memory port with a
// locking round-robin arbiter and in-order read response routing.
module iob_ibus_dbus_merge
    import iob_ibus_dbus_merge_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int PEND_DEPTH = 2,
    localparam int REQ_W  = req_w(ADDR_W, DATA_W),
    localparam int RESP_W = resp_w(DATA_W)
) (
    input  logic              clk_i,
    input  logic              cke_i,
    input  logic              rst_i,
    input  logic [REQ_W-1:0]  i_req_i,
    output logic [RESP_W-1:0] i_resp_o,
    input  logic [REQ_W-1:0]  d_req_i,
    output logic [RESP_W-1:0] d_resp_o,
    output logic [REQ_W-1:0]  m_req_o,
    input  logic [RESP_W-1:0] m_resp_i,
    output logic              err_o
);

    localparam int WSTRB_W = wstrb_w(DATA_W);
    localparam int AV_OFF  = avalid_off(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(PEND_DEPTH + 1);

    logic             grant_s, grant_r, last_r, lock_r, err_r;
    logic [REQ_W-1:0] sel_req_s;
    logic             sel_av_s, sel_rd_s, stall_s, hs_s;
    logic             m_ready_s, m_rvalid_s;
    logic             push_s, pop_s, head_s;
    logic             fifo_full_s, fifo_empty_s;
    logic [CNT_W-1:0] fifo_count_s;

    assign m_ready_s  = m_resp_i[READY_OFF];
    assign m_rvalid_s = m_resp_i[RVALID_OFF];

    // Arbitration: a locked grant wins; otherwise round-robin on ties.
    always_comb begin
        grant_s = grant_r;
        if (lock_r) begin
            grant_s = grant_r;
        end else if (i_req_i[AV_OFF] && d_req_i[AV_OFF]) begin
            grant_s = (last_r == ID_IBUS) ? ID_DBUS : ID_IBUS;
        end else if (d_req_i[AV_OFF]) begin
            grant_s = ID_DBUS;
        end else if (i_req_i[AV_OFF]) begin
            grant_s = ID_IBUS;
        end else begin
            grant_s = grant_r;
        end
    end

    // Request path; a read stalls only while the id FIFO has no slot this cycle.
    always_comb begin
        sel_req_s        = (grant_s == ID_DBUS) ? d_req_i : i_req_i;
        sel_av_s         = sel_req_s[AV_OFF];
        sel_rd_s         = (sel_req_s[WSTRB_OFF +: WSTRB_W] == {WSTRB_W{1'b0}});
        pop_s            = cke_i & m_rvalid_s & (fifo_count_s != {CNT_W{1'b0}});
        stall_s          = sel_rd_s & fifo_full_s & ~pop_s;
        hs_s             = sel_av_s & m_ready_s & ~stall_s;
        push_s           = cke_i & hs_s & sel_rd_s;
        m_req_o          = sel_req_s;
        m_req_o[AV_OFF]  = sel_av_s & ~stall_s;
    end

    // Response routing: ready follows the grant, rvalid follows the FIFO head.
    always_comb begin
        i_resp_o = {RESP_W{1'b0}};
        d_resp_o = {RESP_W{1'b0}};
        i_resp_o[RDATA_OFF +: DATA_W] = m_resp_i[RDATA_OFF +: DATA_W];
        d_resp_o[RDATA_OFF +: DATA_W] = m_resp_i[RDATA_OFF +: DATA_W];
        i_resp_o[READY_OFF]  = (grant_s == ID_IBUS) & m_ready_s & ~stall_s;
        d_resp_o[READY_OFF]  = (grant_s == ID_DBUS) & m_ready_s & ~stall_s;
        i_resp_o[RVALID_OFF] = pop_s & (head_s == ID_IBUS);
        d_resp_o[RVALID_OFF] = pop_s & (head_s == ID_DBUS);
    end

    // Arbiter history, grant lock and sticky spurious-response flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            grant_r <= ID_IBUS;
            last_r  <= ID_IBUS;
            lock_r  <= 1'b0;
            err_r   <= 1'b0;
        end else if (cke_i) begin
            grant_r <= grant_s;
            lock_r  <= sel_av_s & ~m_ready_s;
            if (hs_s) last_r <= grant_s;
            if (m_rvalid_s && fifo_empty_s) err_r <= 1'b1;
        end
    end

    assign err_o = err_r;

    iob_id_fifo #(
        .DEPTH (PEND_DEPTH)
    ) u_id_fifo (
        .clk   (clk_i),
        .cke   (cke_i),
        .rst   (rst_i),
        .push  (push_s),
        .din   (grant_s),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

endmodule
